// File: rtl/sdram_responder.sv
// Chip-side SDR SDRAM emulator: decodes controller commands, tracks open rows per bank,
// returns read data at the programmed CAS latency and latches the first protocol error.
module sdram_responder #(
    parameter int unsigned MEM_AW  = 12,
    parameter int unsigned TRCD    = 2,
    parameter int unsigned INIT_CL = 2
) (
    input  logic        clk50mhz,
    input  logic        reset,
    inout  wire  [15:0] DRAM_DQ,
    input  logic [12:0] DRAM_ADDR,
    input  logic        DRAM_LDQM,
    input  logic        DRAM_UDQM,
    input  logic        DRAM_WE_N,
    input  logic        DRAM_CAS_N,
    input  logic        DRAM_RAS_N,
    input  logic        DRAM_CS_N,
    input  logic        DRAM_BA_0,
    input  logic        DRAM_BA_1,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] refresh_count,
    output logic [1:0]  cas_latency
);

    localparam int unsigned DW     = 16;
    localparam int unsigned RW     = 12;
    localparam int unsigned CW     = 8;
    localparam int unsigned BW     = 2;
    localparam int unsigned NB     = 4;
    localparam int unsigned PIPE   = 3;
    localparam int unsigned FULL_W = BW + RW + CW;
    localparam int unsigned CNT_W  = (TRCD > 0) ? $clog2(TRCD + 1) : 1;

    localparam logic [2:0] CMD_LMR = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_NOP = 3'b111;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CLOSED  = 3'd1;
    localparam logic [2:0] ERR_REOPEN  = 3'd2;
    localparam logic [2:0] ERR_TRCD    = 3'd3;
    localparam logic [2:0] ERR_REFOPEN = 3'd4;
    localparam logic [2:0] ERR_MODE    = 3'd5;
    localparam logic [2:0] ERR_CONTEND = 3'd6;

    logic [NB-1:0]     bank_open;
    logic [RW-1:0]     bank_row [NB];
    logic [CNT_W-1:0]  trcd_cnt [NB];
    logic [PIPE-1:0]   pipe_v;
    logic [DW-1:0]     pipe_d [PIPE];
    logic [DW-1:0]     mem [2**MEM_AW];

    logic [2:0]        cmd_c;
    logic [BW-1:0]     ba_c;
    logic [FULL_W-1:0] full_addr_c;
    logic [MEM_AW-1:0] mem_addr_c;
    logic              bank_hit_c;
    logic              trcd_met_c;
    logic              mode_ok_c;
    logic              rd_fire_c;
    logic              wr_fire_c;
    logic              drive_c;
    logic [1:0]        rd_slot_c;
    logic [2:0]        new_err_c;
    logic              unused_c;

    assign cmd_c       = DRAM_CS_N ? CMD_NOP : {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
    assign ba_c        = {DRAM_BA_1, DRAM_BA_0};
    assign full_addr_c = {ba_c, bank_row[ba_c], DRAM_ADDR[CW-1:0]};
    assign mem_addr_c  = full_addr_c[MEM_AW-1:0];
    assign bank_hit_c  = bank_open[ba_c];
    assign trcd_met_c  = trcd_cnt[ba_c] >= CNT_W'(TRCD);
    assign mode_ok_c   = ((DRAM_ADDR[6:4] == 3'd2) || (DRAM_ADDR[6:4] == 3'd3))
                         && (DRAM_ADDR[2:0] == 3'd0);
    assign rd_fire_c   = (cmd_c == CMD_RD) && bank_hit_c;
    assign wr_fire_c   = (cmd_c == CMD_WR) && bank_hit_c;
    assign rd_slot_c   = cas_latency - 2'd1;
    assign unused_c    = ^{DRAM_ADDR[12], full_addr_c};

    // A WRITE presented while read data is due wins the bus: release DQ for that cycle.
    assign drive_c = pipe_v[0] && (cmd_c != CMD_WR);
    assign DRAM_DQ = drive_c ? pipe_d[0] : {DW{1'bz}};

    // Error classification for the command presented this cycle.
    always_comb begin
        new_err_c = ERR_NONE;
        case (cmd_c)
            CMD_RD: begin
                if (!bank_hit_c)      new_err_c = ERR_CLOSED;
                else if (!trcd_met_c) new_err_c = ERR_TRCD;
            end
            CMD_WR: begin
                if (pipe_v[0])        new_err_c = ERR_CONTEND;
                else if (!bank_hit_c) new_err_c = ERR_CLOSED;
                else if (!trcd_met_c) new_err_c = ERR_TRCD;
            end
            CMD_ACT: if (bank_hit_c)   new_err_c = ERR_REOPEN;
            CMD_REF: if (|bank_open)   new_err_c = ERR_REFOPEN;
            CMD_LMR: if (!mode_ok_c)   new_err_c = ERR_MODE;
            default: new_err_c = ERR_NONE;
        endcase
    end

    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) begin
            bank_open     <= '0;
            pipe_v        <= '0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
            refresh_count <= 16'd0;
            cas_latency   <= 2'(INIT_CL);
            for (int unsigned b = 0; b < NB; b++) begin
                bank_row[b] <= '0;
                trcd_cnt[b] <= '0;
            end
            for (int unsigned i = 0; i < PIPE; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (trcd_cnt[b] < CNT_W'(TRCD)) trcd_cnt[b] <= trcd_cnt[b] + CNT_W'(1);
            end

            // Read pipeline: slot 0 is on the bus; a new read enters at slot CL-1.
            for (int unsigned i = 0; i < PIPE - 1; i++) begin
                pipe_v[i] <= pipe_v[i+1];
                pipe_d[i] <= pipe_d[i+1];
            end
            pipe_v[PIPE-1] <= 1'b0;
            if (rd_fire_c) begin
                pipe_v[rd_slot_c] <= 1'b1;
                pipe_d[rd_slot_c] <= mem[mem_addr_c];
            end

            case (cmd_c)
                CMD_ACT: begin
                    bank_open[ba_c] <= 1'b1;
                    bank_row[ba_c]  <= DRAM_ADDR[RW-1:0];
                    trcd_cnt[ba_c]  <= '0;
                end
                CMD_RD, CMD_WR: begin
                    if (bank_hit_c && DRAM_ADDR[10]) bank_open[ba_c] <= 1'b0;
                end
                CMD_PRE: begin
                    if (DRAM_ADDR[10]) bank_open       <= '0;
                    else               bank_open[ba_c] <= 1'b0;
                end
                CMD_REF: refresh_count <= refresh_count + 16'd1;
                CMD_LMR: if (mode_ok_c) cas_latency <= DRAM_ADDR[5:4];
                default: ;
            endcase

            if (!err && (new_err_c != ERR_NONE)) begin
                err      <= 1'b1;
                err_code <= new_err_c;
            end
        end
    end

    // Backing array survives reset; each byte lane honours its own mask.
    always_ff @(posedge clk50mhz) begin
        if (wr_fire_c) begin
            if (!DRAM_LDQM) mem[mem_addr_c][7:0]  <= DRAM_DQ[7:0];
            if (!DRAM_UDQM) mem[mem_addr_c][15:8] <= DRAM_DQ[15:8];
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: commands driven on the falling edge, read data scored
// against a queue of expected words, status outputs checked inline per scenario.
module tb_sdram_responder;

    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_exp_t;

    logic        clk50mhz = 1'b0;
    logic        reset;
    wire  [15:0] DRAM_DQ;
    logic [12:0] DRAM_ADDR;
    logic        DRAM_LDQM, DRAM_UDQM, DRAM_WE_N, DRAM_CAS_N, DRAM_RAS_N, DRAM_CS_N;
    logic        DRAM_BA_0, DRAM_BA_1;
    logic        err;
    logic [2:0]  err_code;
    logic [15:0] refresh_count;
    logic [1:0]  cas_latency;

    logic        dq_oe;
    logic [15:0] dq_drv;
    rd_exp_t     sb[$];
    rd_exp_t     mon_e;
    logic [15:0] model_mem [int];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          cl_model = 2;

    assign DRAM_DQ = dq_oe ? dq_drv : 16'hzzzz;

    sdram_responder dut (
        .clk50mhz      (clk50mhz),
        .reset         (reset),
        .DRAM_DQ       (DRAM_DQ),
        .DRAM_ADDR     (DRAM_ADDR),
        .DRAM_LDQM     (DRAM_LDQM),
        .DRAM_UDQM     (DRAM_UDQM),
        .DRAM_WE_N     (DRAM_WE_N),
        .DRAM_CAS_N    (DRAM_CAS_N),
        .DRAM_RAS_N    (DRAM_RAS_N),
        .DRAM_CS_N     (DRAM_CS_N),
        .DRAM_BA_0     (DRAM_BA_0),
        .DRAM_BA_1     (DRAM_BA_1),
        .err           (err),
        .err_code      (err_code),
        .refresh_count (refresh_count),
        .cas_latency   (cas_latency)
    );

    always #10 clk50mhz = ~clk50mhz;
    always @(posedge clk50mhz) cyc <= cyc + 1;

    // Scoreboard: what the controller would sample at the upcoming rising edge.
    always @(negedge clk50mhz) begin
        #2;
        if (sb.size() > 0 && sb[0].due == cyc + 1) begin
            mon_e = sb.pop_front();
            checks++;
            if (DRAM_DQ !== mon_e.data) begin
                errors++;
                $display("FAIL read_data edge %0d: got %h expected %h", cyc + 1, DRAM_DQ, mon_e.data);
            end
        end else if (!dq_oe) begin
            checks++;
            if (DRAM_DQ !== 16'hzzzz && DRAM_DQ !== 16'h0000) begin
                errors++;
                $display("FAIL dq_release edge %0d: got %h expected released", cyc + 1, DRAM_DQ);
            end
        end
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            errors++;
            $display("FAIL read_missing: due edge %0d not scored, now %0d", sb[0].due, cyc);
            void'(sb.pop_front());
        end
    end

    function automatic int maddr(input logic [1:0] ba, input logic [11:0] row, input logic [7:0] col);
        logic [21:0] f;
        f = {ba, row, col};
        return int'(f[11:0]);
    endfunction

    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic wr, input logic [15:0] wd, input logic ldqm, input logic udqm);
        @(negedge clk50mhz);
        DRAM_CS_N = 1'b0;
        {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = c;
        {DRAM_BA_1, DRAM_BA_0} = ba;
        DRAM_ADDR = a;
        DRAM_LDQM = ldqm;
        DRAM_UDQM = udqm;
        dq_oe     = wr;
        dq_drv    = wd;
    endtask

    task automatic nop();
        @(negedge clk50mhz);
        DRAM_CS_N = 1'b1;
        {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = 3'b111;
        dq_oe = 1'b0;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) nop();
    endtask

    task automatic activate(input logic [1:0] ba, input logic [11:0] row);
        issue(C_ACT, ba, {1'b0, row}, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic write(input logic [1:0] ba, input logic [11:0] row, input logic [7:0] col,
                         input logic [15:0] wd, input logic ldqm, input logic udqm, input logic ap);
        int          idx;
        logic [15:0] cur;
        issue(C_WR, ba, {2'b00, ap, 2'b00, col}, 1'b1, wd, ldqm, udqm);
        idx = maddr(ba, row, col);
        cur = model_mem.exists(idx) ? model_mem[idx] : 16'h0000;
        if (!ldqm) cur[7:0]  = wd[7:0];
        if (!udqm) cur[15:8] = wd[15:8];
        model_mem[idx] = cur;
    endtask

    task automatic read(input logic [1:0] ba, input logic [11:0] row, input logic [7:0] col,
                        input logic ap, input logic expect_data);
        issue(C_RD, ba, {2'b00, ap, 2'b00, col}, 1'b0, 16'h0, 1'b0, 1'b0);
        if (expect_data) sb.push_back('{due: cyc + 1 + cl_model, data: model_mem[maddr(ba, row, col)]});
    endtask

    task automatic do_reset();
        @(negedge clk50mhz);
        reset = 1'b1;
        DRAM_CS_N = 1'b1;
        {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = 3'b111;
        dq_oe = 1'b0;
        sb.delete();
        cl_model = 2;
        @(negedge clk50mhz);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk50mhz);
        @(negedge clk50mhz);
        #3;
        checks += 4;
        if (err !== 1'b0)            begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        if (err_code !== 3'd0)       begin errors++; $display("FAIL reset_err_code: got %0d expected 0", err_code); end
        if (refresh_count !== 16'd0) begin errors++; $display("FAIL reset_refresh: got %0d expected 0", refresh_count); end
        if (cas_latency !== 2'd2)    begin errors++; $display("FAIL reset_cl: got %0d expected 2", cas_latency); end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        issue(C_LMR, 2'd0, 13'h020, 1'b0, 16'h0, 1'b0, 1'b0);
        nop(); #3;
        checks++;
        if (cas_latency !== 2'd2) begin errors++; $display("FAIL lmr_cl2: got %0d expected 2", cas_latency); end
        activate(2'd0, 12'h123);
        nops(2);
        write(2'd0, 12'h123, 8'h45, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        nop(); #3;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL write_ap_err: got %b expected 0", err); end
        // Re-activating bank0 is only clean if the auto-precharge closed it.
        activate(2'd0, 12'h123);
        nop(); #3;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL autoprecharge_closed: got err_code %0d expected 0", err_code); end
        nop();
        read(2'd0, 12'h123, 8'h45, 1'b0, 1'b1);
        nops(4);
    endtask

    task automatic test_mask();
        write(2'd0, 12'h123, 8'h45, 16'h1234, 1'b1, 1'b0, 1'b0);
        nop();
        read(2'd0, 12'h123, 8'h45, 1'b0, 1'b1);
        nops(4);
        checks++;
        if (model_mem[maddr(2'd0, 12'h123, 8'h45)] !== 16'h12EF) begin
            errors++; $display("FAIL mask_model: got %h expected 12ef", model_mem[maddr(2'd0, 12'h123, 8'h45)]);
        end
    endtask

    task automatic test_back_to_back();
        write(2'd0, 12'h123, 8'h46, 16'h5A5A, 1'b0, 1'b0, 1'b0);
        read(2'd0, 12'h123, 8'h46, 1'b0, 1'b1);
        read(2'd0, 12'h123, 8'h45, 1'b0, 1'b1);
        read(2'd0, 12'h123, 8'h46, 1'b0, 1'b1);
        nops(5);
    endtask

    task automatic test_cl3();
        issue(C_LMR, 2'd0, 13'h030, 1'b0, 16'h0, 1'b0, 1'b0);
        cl_model = 3;
        nop(); #3;
        checks++;
        if (cas_latency !== 2'd3) begin errors++; $display("FAIL lmr_cl3: got %0d expected 3", cas_latency); end
        read(2'd0, 12'h123, 8'h46, 1'b0, 1'b1);
        read(2'd0, 12'h123, 8'h45, 1'b0, 1'b1);
        nops(5);
    endtask

    task automatic test_closed_bank();
        do_reset();
        read(2'd2, 12'h000, 8'h10, 1'b0, 1'b0);
        nop(); #3;
        checks += 2;
        if (err !== 1'b1)      begin errors++; $display("FAIL closed_err: got %b expected 1", err); end
        if (err_code !== 3'd1) begin errors++; $display("FAIL closed_code: got %0d expected 1", err_code); end
        nops(3);
        activate(2'd0, 12'h123);
        nops(2);
        activate(2'd0, 12'h123);
        nop(); #3;
        checks++;
        if (err_code !== 3'd1) begin errors++; $display("FAIL sticky_code: got %0d expected 1", err_code); end
        issue(C_PRE, 2'd0, 13'h400, 1'b0, 16'h0, 1'b0, 1'b0);
        nop();
    endtask

    task automatic test_trcd_refresh();
        do_reset();
        activate(2'd1, 12'h001);
        nops(2);
        write(2'd1, 12'h001, 8'h10, 16'hC0DE, 1'b0, 1'b0, 1'b1);
        nop();
        activate(2'd1, 12'h001);
        read(2'd1, 12'h001, 8'h10, 1'b0, 1'b1);
        nop(); #3;
        checks += 2;
        if (err !== 1'b1)      begin errors++; $display("FAIL trcd_err: got %b expected 1", err); end
        if (err_code !== 3'd3) begin errors++; $display("FAIL trcd_code: got %0d expected 3", err_code); end
        nops(3);
        issue(C_PRE, 2'd0, 13'h400, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) issue(C_REF, 2'd0, 13'h000, 1'b0, 16'h0, 1'b0, 1'b0);
        nop(); #3;
        checks += 2;
        if (refresh_count !== 16'd3) begin errors++; $display("FAIL refresh_count: got %0d expected 3", refresh_count); end
        if (err_code !== 3'd3)       begin errors++; $display("FAIL refresh_code: got %0d expected 3", err_code); end
        activate(2'd3, 12'h0AA);
        issue(C_REF, 2'd0, 13'h000, 1'b0, 16'h0, 1'b0, 1'b0);
        nop(); #3;
        checks++;
        if (refresh_count !== 16'd4) begin errors++; $display("FAIL refresh_open: got %0d expected 4", refresh_count); end
        issue(C_PRE, 2'd3, 13'h000, 1'b0, 16'h0, 1'b0, 1'b0);
        nop();
    endtask

    task automatic test_bad_mode();
        do_reset();
        issue(C_LMR, 2'd0, 13'h021, 1'b0, 16'h0, 1'b0, 1'b0);
        nop(); #3;
        checks += 2;
        if (err_code !== 3'd5)    begin errors++; $display("FAIL mode_code: got %0d expected 5", err_code); end
        if (cas_latency !== 2'd2) begin errors++; $display("FAIL mode_burst_cl: got %0d expected 2", cas_latency); end
        issue(C_LMR, 2'd0, 13'h040, 1'b0, 16'h0, 1'b0, 1'b0);
        nop(); #3;
        checks++;
        if (cas_latency !== 2'd2) begin errors++; $display("FAIL mode_cl4: got %0d expected 2", cas_latency); end
    endtask

    task automatic test_contention();
        do_reset();
        activate(2'd0, 12'h123);
        nops(2);
        read(2'd0, 12'h123, 8'h45, 1'b0, 1'b0);
        nop();
        write(2'd0, 12'h123, 8'h47, 16'h7E57, 1'b0, 1'b0, 1'b0);
        nop(); #3;
        checks++;
        if (err_code !== 3'd6) begin errors++; $display("FAIL contention_code: got %0d expected 6", err_code); end
        read(2'd0, 12'h123, 8'h47, 1'b0, 1'b1);
        nops(4);
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        activate(2'd0, 12'h123);
        nops(2);
        read(2'd0, 12'h123, 8'h45, 1'b0, 1'b0);
        nop();
        @(negedge clk50mhz);
        checks++;
        if (DRAM_DQ !== model_mem[maddr(2'd0, 12'h123, 8'h45)]) begin
            errors++; $display("FAIL pre_reset_drive: got %h expected %h", DRAM_DQ, model_mem[maddr(2'd0, 12'h123, 8'h45)]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (DRAM_DQ !== 16'hzzzz && DRAM_DQ !== 16'h0000) begin
            errors++; $display("FAIL reset_release: got %h expected released", DRAM_DQ);
        end
        @(negedge clk50mhz);
        reset = 1'b0;
        nops(4);
        #3;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL post_reset_err: got %b expected 0", err); end
    endtask

    initial begin
        reset      = 1'b1;
        DRAM_CS_N  = 1'b1;
        DRAM_RAS_N = 1'b1;
        DRAM_CAS_N = 1'b1;
        DRAM_WE_N  = 1'b1;
        DRAM_ADDR  = 13'h0;
        DRAM_BA_0  = 1'b0;
        DRAM_BA_1  = 1'b0;
        DRAM_LDQM  = 1'b0;
        DRAM_UDQM  = 1'b0;
        dq_oe      = 1'b0;
        dq_drv     = 16'h0;

        test_reset();
        test_write_read();
        test_mask();
        test_back_to_back();
        test_cl3();
        test_closed_bank();
        test_trcd_refresh();
        test_bad_mode();
        test_contention();
        test_reset_mid_read();
        nops(4);

        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
